// File: rtl/bound_flasher_monitor.sv
// bound_flasher_monitor
//   Receive-side protocol checker for the bound flasher's 16-bit thermometer
//   LED bus. Each clk the bus is decoded into a lit level (0..16). The monitor
//   follows the legal sequence (up to 16, down to 6, up to 11, down to 0,
//   up to 6, down to 0, idle), flags kickbacks and completed cycles, and
//   reports the first deviation before resynchronising on an all-dark bus.
//
//   Optional feature macro: BOUND_FLASHER_MON_STATS_EN
//     defined   -> kick_count / cycle_count are saturating event counters
//     undefined -> both counters are removed and the ports read as 0
module bound_flasher_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      led,
    output logic [4:0]       level,
    output logic [2:0]       phase,
    output logic             dir_up,
    output logic             busy,
    output logic             kick_pulse,
    output logic             done_pulse,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] kick_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_TURN_DN,
        S_DOWN,
        S_TURN_UP,
        S_RESYNC
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CODE = 2'd1,   // bus is not a thermometer code
        ERR_STEP = 2'd2,   // level moved by more than one
        ERR_SEQ  = 2'd3    // legal step, but not allowed here
    } err_t;

    state_t     state;
    state_t     nxt_state;
    logic [2:0] nxt_phase;
    logic       nxt_kick;
    logic       nxt_done;
    logic       seq_err;
    err_t       err_kind;

    logic [16:0] led_ext;
    logic        sample_ok;
    logic [4:0]  new_lvl;
    logic [4:0]  bound;
    logic        step_up;
    logic        step_dn;
    logic        step_hold;

    // Turning level of each phase: maximum for even (rising) phases,
    // minimum for odd (falling) phases.
    function automatic logic [4:0] phase_bound(input logic [2:0] p);
        case (p)
            3'd0:    phase_bound = 5'd16;
            3'd1:    phase_bound = 5'd6;
            3'd2:    phase_bound = 5'd11;
            3'd4:    phase_bound = 5'd6;
            default: phase_bound = 5'd0;
        endcase
    endfunction

    // Sample decode: a thermometer code plus one has no bits in common with
    // itself; the extra MSB keeps the all-ones bus from wrapping.
    assign led_ext   = {1'b0, led};
    assign sample_ok = ((led_ext + 17'd1) & led_ext) == 17'd0;
    assign new_lvl   = 5'($countones(led));
    assign bound     = phase_bound(phase);
    assign step_up   = sample_ok && (new_lvl == level + 5'd1);
    assign step_dn   = sample_ok && (new_lvl + 5'd1 == level);
    assign step_hold = sample_ok && (new_lvl == level);

    // Next-state decode and error classification for the current sample.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; a missing default infers a latch.
        nxt_state = state;
        nxt_phase = phase;
        nxt_kick  = 1'b0;
        nxt_done  = 1'b0;
        seq_err   = 1'b0;
        err_kind  = ERR_NONE;

        case (state)
            S_IDLE: begin
                if (new_lvl == 5'd0) begin
                    nxt_state = S_IDLE;
                end else if (new_lvl == 5'd1) begin
                    nxt_state = S_UP;
                    nxt_phase = 3'd0;
                end else begin
                    seq_err = 1'b1;
                end
            end
            S_UP: begin
                if (step_up && new_lvl <= bound) begin
                    nxt_state = S_UP;
                end else if (step_hold && level == bound) begin
                    nxt_state = S_TURN_DN;
                    nxt_phase = phase + 3'd1;
                end else begin
                    seq_err = 1'b1;
                end
            end
            S_TURN_DN: begin
                if (step_dn) nxt_state = S_DOWN;
                else         seq_err   = 1'b1;
            end
            S_DOWN: begin
                if (step_dn && new_lvl >= bound) begin
                    nxt_state = S_DOWN;
                end else if (step_hold && level == bound && phase == 3'd5) begin
                    nxt_state = S_IDLE;
                    nxt_phase = 3'd0;
                    nxt_done  = 1'b1;
                end else if (step_hold && level == bound) begin
                    nxt_state = S_TURN_UP;
                    nxt_phase = phase + 3'd1;
                end else if (step_up && (level == 5'd0 || level == 5'd6) &&
                             phase != 3'd5) begin
                    nxt_state = S_UP;
                    nxt_phase = phase - 3'd1;
                    nxt_kick  = 1'b1;
                end else begin
                    seq_err = 1'b1;
                end
            end
            S_TURN_UP: begin
                if (step_up) nxt_state = S_UP;
                else         seq_err   = 1'b1;
            end
            S_RESYNC: begin
                if (sample_ok && new_lvl == 5'd0) begin
                    nxt_state = S_IDLE;
                    nxt_phase = 3'd0;
                end
            end
            default: nxt_state = S_RESYNC;
        endcase

        // Errors are silent while resynchronising; otherwise the most basic
        // cause wins and overrides any event decoded above.
        if (state != S_RESYNC) begin
            if (!sample_ok)                          err_kind = ERR_CODE;
            else if (!(step_up || step_dn || step_hold)) err_kind = ERR_STEP;
            else if (seq_err)                        err_kind = ERR_SEQ;
        end

        if (err_kind != ERR_NONE) begin
            nxt_state = S_RESYNC;
            nxt_phase = phase;
            nxt_kick  = 1'b0;
            nxt_done  = 1'b0;
        end
    end

    // Monitor FSM with registered status and event outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            phase      <= 3'd0;
            level      <= 5'd0;
            dir_up     <= 1'b0;
            busy       <= 1'b0;
            kick_pulse <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values; blocking here would race.
            state      <= nxt_state;
            phase      <= nxt_phase;
            dir_up     <= (nxt_state == S_UP) || (nxt_state == S_TURN_DN);
            busy       <= (nxt_state != S_IDLE) && (nxt_state != S_RESYNC);
            kick_pulse <= nxt_kick;
            done_pulse <= nxt_done;
            err_pulse  <= (err_kind != ERR_NONE);
            if (sample_ok) level <= new_lvl;
            if (err_kind != ERR_NONE) err_code <= err_kind;
        end
    end

`ifdef BOUND_FLASHER_MON_STATS_EN
    // Saturating kickback and completed-cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kick_count  <= '0;
            cycle_count <= '0;
        end else begin
            if (nxt_kick && !(&kick_count))  kick_count  <= kick_count + CNT_W'(1);
            if (nxt_done && !(&cycle_count)) cycle_count <= cycle_count + CNT_W'(1);
        end
    end
`else
    assign kick_count  = '0;
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// tb_bound_flasher_monitor
//   Directed scenarios followed by a long randomized walk. A behavioural
//   model describes the legal sequence as "phase + dwell flag": even phases
//   rise towards their bound, odd phases fall, and a repeated sample at the
//   bound is a dwell that must be followed by a step the other way.
`timescale 1ns/1ps
module tb_bound_flasher_monitor;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_RESYNC = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      led;
    logic [4:0]       level;
    logic [2:0]       phase;
    logic             dir_up;
    logic             busy;
    logic             kick_pulse;
    logic             done_pulse;
    logic             err_pulse;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] kick_count;
    logic [CNT_W-1:0] cycle_count;

    int checks   = 0;
    int failures = 0;
    int kick_seen, done_seen, err_seen;

    // Reference model state
    int m_mode, m_phase, m_level, m_kick, m_cyc, m_code;
    bit m_dwell, m_kp, m_dp, m_ep;
    int bounds [6] = '{16, 6, 11, 0, 6, 0};

    always #5 clk = ~clk;

    bound_flasher_monitor #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .led         (led),
        .level       (level),
        .phase       (phase),
        .dir_up      (dir_up),
        .busy        (busy),
        .kick_pulse  (kick_pulse),
        .done_pulse  (done_pulse),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .kick_count  (kick_count),
        .cycle_count (cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n);
`ifdef BOUND_FLASHER_MON_STATS_EN
        return (n > CNT_MAX) ? CNT_MAX : n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [15:0] therm(input int n);
        return 16'((32'd1 << n) - 1);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_level = 0; m_dwell = 0;
        m_kick = 0; m_cyc = 0; m_code = 0;
        m_kp = 0; m_dp = 0; m_ep = 0;
        kick_seen = 0; done_seen = 0; err_seen = 0;
    endtask

    // Apply one bus sample to the model.
    task automatic model_step(input logic [15:0] v);
        int  n, d, b, delta, code;
        bit  is_therm, legal;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        is_therm = (v == therm(n));
        m_kp = 0; m_dp = 0; m_ep = 0;
        code = 0;
        delta = n - m_level;
        if (m_mode == M_RESYNC) begin
            if (is_therm && n == 0) begin
                m_mode = M_IDLE;
                m_phase = 0;
            end
        end else if (!is_therm) begin
            code = 1;
        end else if (delta > 1 || delta < -1) begin
            code = 2;
        end else begin
            legal = 1;
            if (m_mode == M_IDLE) begin
                if (n == 1) begin
                    m_mode = M_RUN; m_phase = 0; m_dwell = 0;
                end else if (n != 0) begin
                    legal = 0;
                end
            end else begin
                d = (m_phase % 2 == 0) ? 1 : -1;
                b = bounds[m_phase];
                if (m_dwell) begin
                    if (delta == d) m_dwell = 0;
                    else            legal = 0;
                end else if (delta == d && ((d > 0) ? (n <= b) : (n >= b))) begin
                    legal = 1;
                end else if (delta == 0 && m_level == b) begin
                    if (m_phase == 5) begin
                        m_mode = M_IDLE; m_phase = 0; m_dp = 1; m_cyc++;
                    end else begin
                        m_phase++; m_dwell = 1;
                    end
                end else if (d < 0 && delta == 1 && (m_level == 0 || m_level == 6) &&
                             m_phase != 5) begin
                    m_phase--; m_kp = 1; m_kick++;
                end else begin
                    legal = 0;
                end
            end
            if (!legal) code = 3;
        end
        if (code != 0) begin
            m_mode = M_RESYNC; m_ep = 1; m_code = code;
        end
        if (is_therm) m_level = n;
    endtask

    task automatic compare_all();
        check("level",       level,       m_level);
        check("phase",       phase,       m_phase);
        check("dir_up",      dir_up,      (m_mode == M_RUN) && ((m_phase % 2) == int'(m_dwell)));
        check("busy",        busy,        m_mode == M_RUN);
        check("kick_pulse",  kick_pulse,  m_kp);
        check("done_pulse",  done_pulse,  m_dp);
        check("err_pulse",   err_pulse,   m_ep);
        check("err_code",    err_code,    m_code);
        check("kick_count",  kick_count,  sat(m_kick));
        check("cycle_count", cycle_count, sat(m_cyc));
    endtask

    // Drive one sample at the falling edge, let the DUT take it, check at the
    // next falling edge.
    task automatic drive(input logic [15:0] v);
        led = v;
        model_step(v);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (kick_pulse) kick_seen++;
        if (done_pulse) done_seen++;
        if (err_pulse)  err_seen++;
    endtask

    task automatic dl(input int n);
        drive(therm(n));
    endtask

    task automatic ramp(input int a, input int b);
        if (a <= b) for (int i = a; i <= b; i++) dl(i);
        else        for (int i = a; i >= b; i--) dl(i);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        led   = 16'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b1;
    endtask

    // Next stimulus: usually what a well-behaved flasher would send.
    function automatic logic [15:0] gen_next();
        int r, n, d, b;
        r = int'($urandom_range(0, 99));
        if (r < 85) begin
            if (m_mode == M_IDLE) begin
                n = ($urandom_range(0, 3) == 0) ? 0 : 1;
            end else if (m_mode == M_RESYNC) begin
                n = ($urandom_range(0, 2) != 0) ? 0 : m_level;
            end else begin
                d = (m_phase % 2 == 0) ? 1 : -1;
                b = bounds[m_phase];
                if (m_dwell)                                   n = m_level + d;
                else if (d < 0 && (m_level == 0 || m_level == 6) && m_phase != 5 &&
                         $urandom_range(0, 3) == 0)            n = m_level + 1;
                else if (m_level == b)                         n = m_level;
                else                                           n = m_level + d;
            end
            return therm(n);
        end else if (r < 92) begin
            n = m_level + int'($urandom_range(0, 2)) - 1;
            if (n < 0)  n = 0;
            if (n > 16) n = 16;
            return therm(n);
        end else if (r < 97) begin
            return therm(int'($urandom_range(0, 16)));
        end
        return 16'($urandom);
    endfunction

    initial begin
        reset = 1'b0;
        led   = 16'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Clean full cycle
        dl(0); ramp(1, 16); dl(16); ramp(15, 6); dl(6); ramp(7, 11); dl(11);
        ramp(10, 0); dl(0); ramp(1, 6); dl(6); ramp(5, 0); dl(0);
        check("clean_done_pulse", done_pulse, 1);
        check("clean_done_seen",  done_seen, 1);
        check("clean_err_seen",   err_seen, 0);
        check("clean_phase",      phase, 0);
        check("clean_cycle_cnt",  cycle_count, sat(1));

        // Kickback at 6 in phase 1
        apply_reset();
        dl(0); ramp(1, 16); dl(16); ramp(15, 6); dl(7);
        check("kick6_pulse", kick_pulse, 1);
        check("kick6_phase", phase, 0);
        ramp(8, 16); dl(16); ramp(15, 6); dl(6); ramp(7, 11); dl(11);
        ramp(10, 0); dl(0); ramp(1, 6); dl(6); ramp(5, 0); dl(0);
        check("kick6_err_seen",  err_seen, 0);
        check("kick6_kick_cnt",  kick_count, sat(1));
        check("kick6_done_seen", done_seen, 1);

        // Kickback at 0 in phase 3, then the same shape in phase 5 is illegal
        apply_reset();
        dl(0); ramp(1, 16); dl(16); ramp(15, 6); dl(6); ramp(7, 11); dl(11);
        ramp(10, 0); dl(1);
        check("kick0_pulse", kick_pulse, 1);
        check("kick0_phase", phase, 2);
        ramp(2, 11); dl(11); ramp(10, 0); dl(0); ramp(1, 6); dl(6); ramp(5, 0); dl(1);
        check("p5_kick_err_pulse", err_pulse, 1);
        check("p5_kick_err_code",  err_code, 3);
        dl(0);
        check("p5_resync_busy", busy, 0);

        // Non-thermometer code
        drive(16'h0005);
        check("badcode_err_pulse", err_pulse, 1);
        check("badcode_err_code",  err_code, 1);
        check("badcode_busy",      busy, 0);
        dl(0);
        check("badcode_idle_busy", busy, 0);
        check("badcode_code_held", err_code, 1);

        // Step of two while rising
        dl(0); ramp(1, 4); dl(6);
        check("step_err_code", err_code, 2);
        dl(0);

        // Overshoot past 11 in phase 2
        dl(0); ramp(1, 16); dl(16); ramp(15, 6); dl(6); ramp(7, 11); dl(12);
        check("overshoot_err_code", err_code, 3);
        check("overshoot_phase",    phase, 2);
        dl(0);

        // Asynchronous reset in the middle of a falling phase
        dl(0); ramp(1, 16); dl(16); ramp(15, 12);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst_level", level, 0);
        check("arst_phase", phase, 0);
        check("arst_busy",  busy, 0);
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        compare_all();
        dl(0);

        // Five kickbacks: counter saturates
        apply_reset();
        dl(0); ramp(1, 16); dl(16); ramp(15, 6); dl(7);
        for (int k = 0; k < 4; k++) begin
            ramp(8, 16); dl(16); ramp(15, 6); dl(7);
        end
        check("sat_kick_seen",  kick_seen, 5);
        check("sat_kick_count", kick_count, sat(5));
        dl(0); dl(0);

        // Randomized walk
        apply_reset();
        for (int c = 0; c < 4000; c++) drive(gen_next());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bound_flasher_monitor.md
Name: bound_flasher_monitor

Overview:
- Receive-side checker and decoder for the 16-bit thermometer LED bus driven by the bound flasher.
- Samples the bus every clk and decodes the lit level (0..16). Tracks direction and phase index (0..5), flags kickback (flick) events and pulses on completed cycles.
- Reports any deviation from the legal flasher sequence: up to 16, down to 6, up to 11, down to 0, up to 6, down to 0, then idle.
- Sits beside the flasher in the system and in the bench as a protocol monitor; the flasher is unmodified.

Parameters:
CNT_W, 8, width of kick_count and cycle_count; both counters saturate at all-ones.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
led  input  16  flasher LED bus, sampled each rising clk
level  output  5  decoded lit count of last valid sample
phase  output  3  current phase index 0..5, equal to flasher index
dir_up  output  1  1 = UP or TURN_DN, 0 otherwise
busy  output  1  1 when state is not IDLE or RESYNC
kick_pulse  output  1  one-cycle pulse on a detected kickback
done_pulse  output  1  one-cycle pulse on cycle completion
err_pulse  output  1  one-cycle pulse on a protocol error
err_code  output  2  cause of last error, held until next error: 1 non-thermometer, 2 step larger than 1, 3 sequence violation
kick_count  output  CNT_W  saturating kickback count
cycle_count  output  CNT_W  saturating completed-cycle count

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0, including err_code.
- Decode:
  - Sample is valid iff (led+1) & led == 0, computed at 17 bits.
  - new = popcount; prev = level register.
  - delta = new-prev must be -1, 0 or +1.
  - All outputs are registered: an event on the sample at edge N is visible after edge N.
- Per-phase bounds: max/min = P0 16/-, P1 -/6, P2 11/-, P3 -/0, P4 6/-, P5 -/0.
- States: IDLE, UP, TURN_DN, DOWN, TURN_UP, RESYNC.
- IDLE:
  - new=0: stay.
  - new=1: go to UP, phase=0.
  - Anything else is a sequence error.
- UP:
  - +1 with new<=max: stay.
  - 0 with prev==max: go to TURN_DN, phase+1 (dwell cycle).
  - Any other input is a sequence error: stall below max, reversal without dwell, or overshoot.
- TURN_DN: -1 goes to DOWN. Anything else is a sequence error.
- DOWN:
  - -1 with new>=min: stay.
  - 0 with prev==min and phase==5: go to IDLE, pulse done_pulse, cycle_count+1.
  - 0 with prev==min and phase<5: go to TURN_UP, phase+1.
  - +1 with prev in {0,6} and phase!=5: kickback. Go to UP, phase-1, pulse kick_pulse, kick_count+1.
  - Any other input is a sequence error.
- TURN_UP: +1 goes to UP. Anything else is a sequence error.
- Error priority: non-thermometer (1) > step (2) > sequence (3).
- On any error:
  - pulse err_pulse, latch err_code, go to RESYNC.
  - level still updates when the sample is valid.
- RESYNC: wait for a valid new=0 sample, then go to IDLE with phase=0. No further errors are reported while in RESYNC.
- A flasher reset mid-cycle shows as a drop to 0. That is a step error unless prev==1, then RESYNC/IDLE; the bench must account for this.
- Simultaneous events: at most one of kick_pulse, done_pulse, err_pulse per cycle, by construction.
- Counter saturation: kick_count and cycle_count stop at all-ones with no wrap.

Optional Feature:
- Macro: BOUND_FLASHER_MON_STATS_EN.
- Defined: kick_count and cycle_count are implemented as specified.
- Undefined: both count registers are removed and the ports are tied to 0. Pulses, err_code and all other behaviour are unchanged.

Test Plan:
- Clean cycle: 0,1..16,16,15..6,6,7..11,11,10..0,0,1..6,6,5..0,0 -> done_pulse once after the final 0 repeat; cycle_count=1; phase returns to 0; no err_pulse.
- Kickback at 6: P1 samples 8,7,6,7 -> kick_pulse after 7; phase 1->0; then climb to 16 is legal; kick_count=1.
- Kickback at 0: P3 samples 1,0,1 -> kick_pulse; phase 3->2; climb to 11 legal. Same 1,0,1 in P5 -> err_code=3.
- Bad code: led=16'h0005 -> err_pulse, err_code=1, RESYNC. Then led=0 -> IDLE, busy=0.
- Step and overshoot: UP at 4 -> 6 gives err_code=2. P2 at 11 -> 12 gives err_code=3.
- Async reset mid-DOWN, and saturation with CNT_W=2: 5 kickbacks -> kick_count=3. With macro undefined -> kick_count stays 0.
